// File: rtl/prefetch_pkg.sv
// Shared definitions for the store buffer: FSM state encoding and default geometry.
package prefetch_pkg;

   typedef enum logic [1:0] {
      ST_RUN   = 2'd0,
      ST_FLUSH = 2'd1,
      ST_DONE  = 2'd2
   } sbuf_state_t;

   localparam int SBUF_DEPTH = 8;
   localparam int SBUF_AW    = 8;
   localparam int SBUF_DW    = 32;

endpackage

// File: rtl/sbuf_cam_match.sv
// Youngest-match selector: scans the ring from oldest slot (tail) to youngest (tail-1).
module sbuf_cam_match #(
   parameter int DEPTH = 8,
   localparam int PW   = $clog2(DEPTH)
) (
   input  logic [DEPTH-1:0] match,
   input  logic [PW-1:0]    tail,
   output logic             hit,
   output logic [PW-1:0]    idx
);

   logic [PW-1:0] pos;

   // Later hits overwrite earlier ones, so the last match seen is the youngest.
   always_comb begin
      hit = 1'b0;
      idx = '0;
      pos = '0;
      for (int k = 0; k < DEPTH; k++) begin
         pos = tail + PW'(k);
         if (match[pos]) begin
            hit = 1'b1;
            idx = pos;
         end
      end
   end

endmodule

// File: rtl/store_buf_fwd.sv
// Store buffer: circular FIFO of stores draining to memory, with registered load forwarding.
module store_buf_fwd
   import prefetch_pkg::*;
#(
   parameter int DEPTH = SBUF_DEPTH,
   parameter int AW    = SBUF_AW,
   parameter int DW    = SBUF_DW,
   localparam int PW   = $clog2(DEPTH),
   localparam int CW   = $clog2(DEPTH) + 1
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          st_valid,
   input  logic [AW-1:0] st_addr,
   input  logic [DW-1:0] st_data,
   output logic          st_ready,
   input  logic          ld_valid,
   input  logic [AW-1:0] ld_addr,
   output logic          ld_rvalid,
   output logic          ld_hit,
   output logic [DW-1:0] ld_data,
   output logic          mem_wvalid,
   output logic [AW-1:0] mem_waddr,
   output logic [DW-1:0] mem_wdata,
   input  logic          mem_wready,
   input  logic          flush_req,
   output logic          flush_done,
   output logic [CW-1:0] count,
   output sbuf_state_t   state_dbg
);

   // Handshakes: a transfer happens on a rising edge where valid and ready are both high;
   // the producer holds payload stable while valid is high and ready is low.

   logic [AW-1:0]    addr_q [DEPTH];
   logic [DW-1:0]    data_q [DEPTH];
   logic [DEPTH-1:0] valid_q;
   logic [PW-1:0]    head, tail;
   sbuf_state_t      state;

   logic             enq, deq;
   logic [DEPTH-1:0] match;
   logic             cam_hit;
   logic [PW-1:0]    cam_idx;

   assign st_ready   = (state == ST_RUN) && (count != CW'(DEPTH));
   assign mem_wvalid = (count != '0);
   assign mem_waddr  = mem_wvalid ? addr_q[head] : '0;
   assign mem_wdata  = mem_wvalid ? data_q[head] : '0;
   assign enq        = st_valid && st_ready;
   assign deq        = mem_wvalid && mem_wready;
   assign state_dbg  = state;

   always_comb begin
      match = '0;
      for (int i = 0; i < DEPTH; i++)
         match[i] = valid_q[i] && (addr_q[i] == ld_addr);
   end

   sbuf_cam_match #(.DEPTH(DEPTH)) u_cam (
      .match (match),
      .tail  (tail),
      .hit   (cam_hit),
      .idx   (cam_idx)
   );

   always_ff @(posedge clk) begin
      if (enq) begin
         addr_q[tail] <= st_addr;
         data_q[tail] <= st_data;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         head       <= '0;
         tail       <= '0;
         count      <= '0;
         valid_q    <= '0;
         state      <= ST_RUN;
         flush_done <= 1'b0;
         ld_rvalid  <= 1'b0;
         ld_hit     <= 1'b0;
         ld_data    <= '0;
      end else begin
         if (enq) begin
            tail          <= tail + PW'(1);
            valid_q[tail] <= 1'b1;
         end
         if (deq) begin
            head          <= head + PW'(1);
            valid_q[head] <= 1'b0;
         end
         if (enq && !deq)
            count <= count + CW'(1);
         else if (!enq && deq)
            count <= count - CW'(1);

         // Lookup sees pre-edge entries: same-cycle enqueue hidden, same-cycle dequeue visible.
         ld_rvalid <= ld_valid;
         ld_hit    <= ld_valid && cam_hit;
         ld_data   <= (ld_valid && cam_hit) ? data_q[cam_idx] : '0;

         flush_done <= 1'b0;
         case (state)
            ST_RUN:   if (flush_req) state <= ST_FLUSH;
            ST_FLUSH: if (count == '0) begin
                         state      <= ST_DONE;
                         flush_done <= 1'b1;
                      end
            ST_DONE:  state <= ST_RUN;
            default:  state <= ST_RUN;
         endcase
      end
   end

endmodule
